pwm_cfg_update_scheduler: RTL and testbench

Sequences configuration updates from the SPI register bank into the PWM output stage. It owns the PWM period timebase (prescaler plus 8-bit period counter). It holds the staged register values written over SPI until they have been stable for a programmable window. It then commits all five registers atomically at the next PWM period boundary, so outputs never see half-written or mid-period configuration.

---
 rtl/pwm_cfg_update_scheduler.sv | 130 +++++++++++++
 tb/tb_pwm_cfg_update_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_update_scheduler.sv
// PWM configuration update scheduler.
// Owns the PWM period timebase. It lets staged SPI register values settle
// for a programmable window, then commits all five registers atomically at
// the next period boundary, so the output stage never sees half-written or
// mid-period configuration. force_commit bypasses the settle window and
// restarts the period.
module pwm_cfg_update_scheduler #(
  parameter int PRESCALE_DIV  = 13,  // clk cycles per pwm_cnt increment (>= 1)
  parameter int STABLE_CYCLES = 16   // unchanged cycles before a commit is armed (>= 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] stg_out_7_0,
  input  logic [7:0] stg_out_15_8,
  input  logic [7:0] stg_pwm_7_0,
  input  logic [7:0] stg_pwm_15_8,
  input  logic [7:0] stg_duty,
  input  logic       force_commit,
  output logic [7:0] act_out_7_0,
  output logic [7:0] act_out_15_8,
  output logic [7:0] act_pwm_7_0,
  output logic [7:0] act_pwm_15_8,
  output logic [7:0] act_duty,
  output logic [7:0] pwm_cnt,
  output logic       period_start,
  output logic       commit,
  output logic       update_pending
);

  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int SW = $clog2(STABLE_CYCLES) + 1;

  localparam logic [PW-1:0] PRE_LAST    = PW'(PRESCALE_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] ARMED  = 2'd2;

  logic [PW-1:0] prescaler;
  logic [1:0]    state;
  logic [39:0]   snap;
  logic [39:0]   act;
  logic [SW-1:0] stable_cnt;
  logic [39:0]   stg;
  logic          tick;
  logic          boundary;

  // The staged and active values use the same byte order, so the two can be
  // compared directly as single words.
  assign stg = {stg_out_15_8, stg_out_7_0, stg_pwm_15_8, stg_pwm_7_0, stg_duty};
  assign {act_out_15_8, act_out_7_0, act_pwm_15_8, act_pwm_7_0, act_duty} = act;

  assign tick           = (prescaler == PRE_LAST);
  assign boundary       = tick && (pwm_cnt == 8'hFF);
  assign update_pending = (state != IDLE);

  // Timebase: prescaler and period counter. A force restarts the period.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      prescaler    <= '0;
      pwm_cnt      <= 8'd0;
      period_start <= 1'b0;
    end else if (force_commit) begin
      prescaler    <= '0;
      pwm_cnt      <= 8'd0;
      period_start <= 1'b1;
    end else begin
      period_start <= boundary;
      prescaler    <= tick ? '0 : prescaler + PW'(1);
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Update sequencing: settle window, arming, and the atomic commit at the boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      snap       <= '0;
      stable_cnt <= '0;
      act        <= '0;
      commit     <= 1'b0;
    end else if (force_commit) begin
      act        <= stg;
      stable_cnt <= '0;
      state      <= IDLE;
      commit     <= 1'b1;
    end else begin
      commit <= 1'b0;
      case (state)
        IDLE: begin
          if (stg != act) begin
            snap       <= stg;
            stable_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (stg == act) begin
            state <= IDLE;
          end else if (stg != snap) begin
            snap       <= stg;
            stable_cnt <= '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state <= ARMED;
          end else begin
            stable_cnt <= stable_cnt + SW'(1);
          end
        end
        ARMED: begin
          // A late write wins over the boundary: restart settling instead of
          // committing a value that is already stale.
          if (stg != snap) begin
            snap       <= stg;
            stable_cnt <= '0;
            state      <= SETTLE;
          end else if (boundary) begin
            act    <= snap;
            state  <= IDLE;
            commit <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_cfg_update_scheduler.sv
// Self-checking bench for pwm_cfg_update_scheduler.
// The driver advances a window-based reference model and queues every
// expected commit. A negedge monitor pops the queue and checks the outputs.
module tb_pwm_cfg_update_scheduler;

  localparam int P   = 2;
  localparam int N   = 4;
  localparam int PER = 256 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       force_commit = 1'b0;
  logic [7:0] stg_out_7_0 = 8'hFF, stg_out_15_8 = 8'hFF;
  logic [7:0] stg_pwm_7_0 = 8'hFF, stg_pwm_15_8 = 8'hFF, stg_duty = 8'hFF;
  logic [7:0] act_out_7_0, act_out_15_8, act_pwm_7_0, act_pwm_15_8, act_duty;
  logic [7:0] pwm_cnt;
  logic       period_start, commit, update_pending;
  logic [39:0] dut_act;

  pwm_cfg_update_scheduler #(.PRESCALE_DIV(P), .STABLE_CYCLES(N)) dut (
    .clk(clk), .rst(rst),
    .stg_out_7_0(stg_out_7_0), .stg_out_15_8(stg_out_15_8),
    .stg_pwm_7_0(stg_pwm_7_0), .stg_pwm_15_8(stg_pwm_15_8),
    .stg_duty(stg_duty), .force_commit(force_commit),
    .act_out_7_0(act_out_7_0), .act_out_15_8(act_out_15_8),
    .act_pwm_7_0(act_pwm_7_0), .act_pwm_15_8(act_pwm_15_8),
    .act_duty(act_duty), .pwm_cnt(pwm_cnt), .period_start(period_start),
    .commit(commit), .update_pending(update_pending)
  );

  assign dut_act = {act_out_15_8, act_out_7_0, act_pwm_15_8, act_pwm_7_0, act_duty};

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [39:0] act;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: cycles since the last period restart, the committed
  // word, and how many consecutive out-of-reset cycles the staged word has held.
  int          k    = 0;
  int          run  = 0;
  logic [39:0] a_m  = '0;
  logic [39:0] prev_s = '0;
  logic [39:0] cur_s  = {40{1'b1}};

  logic        cur_valid = 1'b0, nxt_valid = 1'b0;
  logic [39:0] cur_act, nxt_act;
  logic [7:0]  cur_pwm, nxt_pwm;
  logic        cur_ps, nxt_ps, cur_pend, nxt_pend, cur_pk, nxt_pk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, actual, required);
    end
  endtask

  // Drive one cycle: apply inputs just after the edge and predict the
  // outputs visible after the following edge.
  task automatic step(input logic r, input logic f);
    logic [39:0] s;
    int          kn;
    logic        cm;
    @(posedge clk);
    #1;
    cyc++;
    cur_valid = nxt_valid;
    cur_act   = nxt_act;
    cur_pwm   = nxt_pwm;
    cur_ps    = nxt_ps;
    cur_pend  = nxt_pend;
    cur_pk    = nxt_pk;

    s = cur_s;
    rst = r;
    force_commit = f;
    {stg_out_15_8, stg_out_7_0, stg_pwm_15_8, stg_pwm_7_0, stg_duty} = s;

    if (r) run = 0;
    else if (run != 0 && s == prev_s) run++;
    else run = 1;
    prev_s = s;

    cm = 1'b0;
    if (r) begin
      a_m = '0; kn = 0; nxt_ps = 1'b0; nxt_pend = 1'b0; nxt_pk = 1'b1;
    end else if (f) begin
      a_m = s; kn = 0; nxt_ps = 1'b1; cm = 1'b1; nxt_pend = 1'b0; nxt_pk = 1'b1;
    end else begin
      kn = k + 1;
      nxt_ps = ((kn % PER) == 0);
      // Commit at a boundary only if the staged word differs from the active
      // one and has held still for the settle window plus the arming cycle.
      if (((k % PER) == PER - 1) && run >= N + 2 && s != a_m) begin
        a_m = s; cm = 1'b1; nxt_pend = 1'b0; nxt_pk = 1'b1;
      end else begin
        nxt_pend = (s != a_m);
        // A fresh write back to the active value may still leave one settle cycle.
        nxt_pk   = !(s == a_m && run == 1);
      end
    end
    k         = kn;
    nxt_act   = a_m;
    nxt_pwm   = 8'((k / P) % 256);
    nxt_valid = 1'b1;
    if (cm) sb_q.push_back('{cyc + 1, a_m});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Advance until the next driven cycle sits at the requested period phase.
  task automatic to_phase(input int ph);
    int guard;
    guard = 0;
    while ((k % PER) != ph && guard < 2 * PER) begin
      step(1'b0, 1'b0);
      guard++;
    end
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop on every commit.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (cur_valid) begin
      check("act_hold", dut_act, cur_act);
      check("pwm_cnt", pwm_cnt, cur_pwm);
      check("period_start", period_start, cur_ps);
      if (cur_pk) check("update_pending", update_pending, cur_pend);
      if (commit === 1'b1 || (sb_q.size() > 0 && sb_q[0].cyc <= cyc)) begin
        if (sb_q.size() == 0) begin
          check("commit_unexpected", commit, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("commit_cycle", cyc, e.cyc);
          check("commit", commit, 1'b1);
          check("commit_act", dut_act, e.act);
        end
      end
    end
  end

  initial begin
    // Reset held with all-ones staged; commit lands on the first boundary.
    cur_s = {40{1'b1}};
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    idle(PER + 8);

    // Mid-period duty write from zero: force duty to 0 first, then write 0x80 at pwm_cnt 10.
    cur_s[7:0] = 8'h00;
    step(1'b0, 1'b1);
    to_phase(20);
    cur_s[7:0] = 8'h80;
    to_phase(PER - 1);
    idle(4);

    // Split SPI writes two cycles apart commit together.
    to_phase(40);
    cur_s[31:24] = 8'h0F;
    idle(2);
    cur_s[39:32] = 8'hF0;
    to_phase(PER - 1);
    idle(4);

    // Change during the boundary cycle defers the commit one full period.
    to_phase(30);
    cur_s[15:8] = 8'h01;
    to_phase(PER - 1);
    cur_s[15:8] = 8'h03;
    step(1'b0, 1'b0);
    to_phase(PER - 1);
    idle(4);

    // force_commit at pwm_cnt 100.
    to_phase(200);
    cur_s[7:0] = 8'h40;
    step(1'b0, 1'b1);
    idle(3);

    // Revert within two cycles: no commit at the next boundary.
    cur_s[7:0] = 8'h20;
    step(1'b0, 1'b1);
    idle(2);
    cur_s[7:0] = 8'h30;
    step(1'b0, 1'b0);
    cur_s[7:0] = 8'h20;
    to_phase(PER - 1);
    idle(4);

    // force_commit held with changing staged values.
    for (int i = 0; i < 3; i++) begin
      cur_s[7:0] = 8'($urandom);
      step(1'b0, 1'b1);
    end
    idle(3);

    // Reset mid-settle discards the pending update.
    cur_s[23:16] = 8'h5A;
    idle(2);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    idle(20);

    // Randomized traffic with extra activity around boundaries.
    for (int i = 0; i < 3000; i++) begin
      logic r, f;
      int   bi;
      r = ($urandom_range(0, 999) == 0);
      f = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0 ||
          ((k % PER) >= PER - 8 && $urandom_range(0, 3) == 0)) begin
        bi = $urandom_range(0, 4);
        cur_s[bi*8 +: 8] = 8'($urandom);
      end
      step(r, f);
    end

    // Drain: hold inputs across a full period so every queued commit resolves.
    idle(PER + 10);
    check("scoreboard_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
